// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode constants and entry types for the ALU reservation station.
// Operand wakeup is a helper so that dispatch and stored entries use identical matching rules.
package reservation_station_pkg;

  localparam int DATA_W    = 32;
  localparam int RS_SIZE   = 16;
  localparam int RS_WIDTH  = 4;
  localparam int ROB_WIDTH = 4;
  localparam int OPT_WIDTH = 6;
  localparam int CNT_W     = RS_WIDTH + 1;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_WIDTH-1:0] rob_t;
  typedef logic [OPT_WIDTH-1:0] opt_t;

  // ALU-class operation codes (loads/stores never reach this station)
  localparam opt_t OPT_NONE  = 6'd0;
  localparam opt_t OPT_LUI   = 6'd1;
  localparam opt_t OPT_AUIPC = 6'd2;
  localparam opt_t OPT_JAL   = 6'd3;
  localparam opt_t OPT_JALR  = 6'd4;
  localparam opt_t OPT_BEQ   = 6'd5;
  localparam opt_t OPT_BNE   = 6'd6;
  localparam opt_t OPT_BLT   = 6'd7;
  localparam opt_t OPT_BGE   = 6'd8;
  localparam opt_t OPT_BLTU  = 6'd9;
  localparam opt_t OPT_BGEU  = 6'd10;
  localparam opt_t OPT_ADDI  = 6'd19;
  localparam opt_t OPT_SLTI  = 6'd20;
  localparam opt_t OPT_SLTIU = 6'd21;
  localparam opt_t OPT_XORI  = 6'd22;
  localparam opt_t OPT_ORI   = 6'd23;
  localparam opt_t OPT_ANDI  = 6'd24;
  localparam opt_t OPT_SLLI  = 6'd25;
  localparam opt_t OPT_SRLI  = 6'd26;
  localparam opt_t OPT_SRAI  = 6'd27;
  localparam opt_t OPT_ADD   = 6'd28;
  localparam opt_t OPT_SUB   = 6'd29;
  localparam opt_t OPT_SLL   = 6'd30;
  localparam opt_t OPT_SLT   = 6'd31;
  localparam opt_t OPT_SLTU  = 6'd32;
  localparam opt_t OPT_XOR   = 6'd33;
  localparam opt_t OPT_SRL   = 6'd34;
  localparam opt_t OPT_SRA   = 6'd35;
  localparam opt_t OPT_OR    = 6'd36;
  localparam opt_t OPT_AND   = 6'd37;

  typedef struct packed {
    rob_t  rob_alias;
    opt_t  inst_type;
    data_t vi;
    data_t vj;
    rob_t  qi;
    rob_t  qj;
    data_t imm;
    data_t pc;
  } rs_entry_t;

  typedef struct packed {
    rob_t  q;
    data_t v;
  } operand_t;

  // ALU broadcast wins over LSB; a zero tag means the value is already present.
  function automatic operand_t snoop(operand_t op,
                                     logic alu_v, rob_t alu_a, data_t alu_r,
                                     logic lsb_v, rob_t lsb_a, data_t lsb_r);
    operand_t res;
    res = op;
    if (op.q != '0) begin
      if (alu_v && (alu_a == op.q)) begin
        res.q = '0;
        res.v = alu_r;
      end else if (lsb_v && (lsb_a == op.q)) begin
        res.q = '0;
        res.v = lsb_r;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_priority_enc.sv
// Lowest-index-set-bit finder; used for both free-slot allocation and issue selection.
module rs_priority_enc #(
  parameter int SIZE = 16,
  localparam int W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] vec_i,
  output logic            found_o,
  output logic [W-1:0]    idx_o
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Unified ALU reservation station: buffers dispatched ops, snoops ALU/LSB results,
// and issues the lowest-index ready entry to the ALU each cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,

  input  logic                 valid_from_dispatcher,
  input  logic [ROB_WIDTH-1:0] alias_from_dispatcher,
  input  logic [OPT_WIDTH-1:0] inst_type_from_dispatcher,
  input  logic [DATA_W-1:0]    Vi_from_dispatcher,
  input  logic [DATA_W-1:0]    Vj_from_dispatcher,
  input  logic [ROB_WIDTH-1:0] Qi_from_dispatcher,
  input  logic [ROB_WIDTH-1:0] Qj_from_dispatcher,
  input  logic [DATA_W-1:0]    imm_from_dispatcher,
  input  logic [DATA_W-1:0]    pc_from_dispatcher,

  input  logic                 valid_from_alu,
  input  logic [ROB_WIDTH-1:0] alias_from_alu,
  input  logic [DATA_W-1:0]    result_from_alu,
  input  logic                 valid_from_lsb,
  input  logic [ROB_WIDTH-1:0] alias_from_lsb,
  input  logic [DATA_W-1:0]    result_from_lsb,

  output logic                 full,
  output logic                 valid_to_alu,
  output logic [ROB_WIDTH-1:0] alias_to_alu,
  output logic [OPT_WIDTH-1:0] inst_type_to_alu,
  output logic [DATA_W-1:0]    Vi_to_alu,
  output logic [DATA_W-1:0]    Vj_to_alu,
  output logic [DATA_W-1:0]    imm_to_alu,
  output logic [DATA_W-1:0]    pc_to_alu
);

  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]  busy_q, busy_d;
  logic                issue_valid_q, issue_valid_d;
  rs_entry_t           issue_q, issue_d;

  logic [RS_SIZE-1:0]  ready_vec;
  logic [CNT_W-1:0]    busy_cnt;
  logic                free_found, sel_found;
  logic [RS_WIDTH-1:0] free_idx, sel_idx;

  operand_t            op_i, op_j;
  rs_entry_t           new_ent;

  // Ready and occupancy are derived from registered state only.
  always_comb begin
    ready_vec = '0;
    busy_cnt  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && (ent_q[i].qi == '0) && (ent_q[i].qj == '0);
      busy_cnt     = busy_cnt + CNT_W'(busy_q[i]);
    end
  end

  // One slot of headroom covers the dispatch already in flight when full rises.
  assign full = (busy_cnt >= CNT_W'(RS_SIZE - 1));

  rs_priority_enc #(.SIZE(RS_SIZE)) u_free_enc (
    .vec_i   (~busy_q),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_priority_enc #(.SIZE(RS_SIZE)) u_issue_enc (
    .vec_i   (ready_vec),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_comb begin
    ent_d         = ent_q;
    busy_d        = busy_q;
    issue_valid_d = 1'b0;
    issue_d       = issue_q;
    op_i          = '0;
    op_j          = '0;
    new_ent       = '0;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        op_i = snoop('{q: ent_q[i].qi, v: ent_q[i].vi},
                     valid_from_alu, alias_from_alu, result_from_alu,
                     valid_from_lsb, alias_from_lsb, result_from_lsb);
        op_j = snoop('{q: ent_q[i].qj, v: ent_q[i].vj},
                     valid_from_alu, alias_from_alu, result_from_alu,
                     valid_from_lsb, alias_from_lsb, result_from_lsb);
        ent_d[i].qi = op_i.q;
        ent_d[i].vi = op_i.v;
        ent_d[i].qj = op_j.q;
        ent_d[i].vj = op_j.v;
      end
    end

    if (sel_found) begin
      issue_valid_d   = 1'b1;
      issue_d         = ent_q[sel_idx];
      busy_d[sel_idx] = 1'b0;
    end

    // free_idx comes from busy_q, so a slot vacated by this cycle's issue is never reused here.
    if (valid_from_dispatcher && free_found) begin
      op_i = snoop('{q: Qi_from_dispatcher, v: Vi_from_dispatcher},
                   valid_from_alu, alias_from_alu, result_from_alu,
                   valid_from_lsb, alias_from_lsb, result_from_lsb);
      op_j = snoop('{q: Qj_from_dispatcher, v: Vj_from_dispatcher},
                   valid_from_alu, alias_from_alu, result_from_alu,
                   valid_from_lsb, alias_from_lsb, result_from_lsb);
      new_ent.rob_alias = alias_from_dispatcher;
      new_ent.inst_type = inst_type_from_dispatcher;
      new_ent.qi        = op_i.q;
      new_ent.vi        = op_i.v;
      new_ent.qj        = op_j.q;
      new_ent.vj        = op_j.v;
      new_ent.imm       = imm_from_dispatcher;
      new_ent.pc        = pc_from_dispatcher;
      ent_d[free_idx]   = new_ent;
      busy_d[free_idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (rdy) begin
      busy_q        <= busy_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  // Entry payload is qualified by busy_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy && !(rst || rollback)) begin
      ent_q <= ent_d;
    end
  end

  assign valid_to_alu     = issue_valid_q;
  assign alias_to_alu     = issue_q.rob_alias;
  assign inst_type_to_alu = issue_q.inst_type;
  assign Vi_to_alu        = issue_q.vi;
  assign Vj_to_alu        = issue_q.vj;
  assign imm_to_alu       = issue_q.imm;
  assign pc_to_alu        = issue_q.pc;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner sequences,
// and randomized traffic against a slot-level reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, rollback;
  logic valid_from_dispatcher;
  rob_t alias_from_dispatcher, Qi_from_dispatcher, Qj_from_dispatcher;
  opt_t inst_type_from_dispatcher;
  data_t Vi_from_dispatcher, Vj_from_dispatcher, imm_from_dispatcher, pc_from_dispatcher;
  logic valid_from_alu, valid_from_lsb;
  rob_t alias_from_alu, alias_from_lsb;
  data_t result_from_alu, result_from_lsb;
  logic full, valid_to_alu;
  rob_t alias_to_alu;
  opt_t inst_type_to_alu;
  data_t Vi_to_alu, Vj_to_alu, imm_to_alu, pc_to_alu;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .valid_from_dispatcher(valid_from_dispatcher),
    .alias_from_dispatcher(alias_from_dispatcher),
    .inst_type_from_dispatcher(inst_type_from_dispatcher),
    .Vi_from_dispatcher(Vi_from_dispatcher), .Vj_from_dispatcher(Vj_from_dispatcher),
    .Qi_from_dispatcher(Qi_from_dispatcher), .Qj_from_dispatcher(Qj_from_dispatcher),
    .imm_from_dispatcher(imm_from_dispatcher), .pc_from_dispatcher(pc_from_dispatcher),
    .valid_from_alu(valid_from_alu), .alias_from_alu(alias_from_alu),
    .result_from_alu(result_from_alu),
    .valid_from_lsb(valid_from_lsb), .alias_from_lsb(alias_from_lsb),
    .result_from_lsb(result_from_lsb),
    .full(full), .valid_to_alu(valid_to_alu), .alias_to_alu(alias_to_alu),
    .inst_type_to_alu(inst_type_to_alu), .Vi_to_alu(Vi_to_alu), .Vj_to_alu(Vj_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: slot array, lowest free slot on dispatch, lowest ready slot on issue.
  logic      m_busy [RS_SIZE];
  rs_entry_t m_ent  [RS_SIZE];
  logic      m_valid;
  rs_entry_t m_out;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < RS_SIZE; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic hit(rob_t q, output data_t v);
    v = '0;
    if (q == 0) return 1'b0;
    if (valid_from_alu && alias_from_alu == q) begin v = result_from_alu; return 1'b1; end
    if (valid_from_lsb && alias_from_lsb == q) begin v = result_from_lsb; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int sel, fr;
    data_t d;
    rs_entry_t ne;
    if (rst || rollback) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
      m_valid = 1'b0;
      m_out = '0;
      return;
    end
    if (!rdy) return;
    sel = -1;
    fr = -1;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (m_busy[i] && m_ent[i].qi == 0 && m_ent[i].qj == 0) sel = i;
      if (!m_busy[i]) fr = i;
    end
    if (sel >= 0) begin
      m_valid = 1'b1;
      m_out = m_ent[sel];
      m_busy[sel] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m_busy[i]) begin
        if (hit(m_ent[i].qi, d)) begin m_ent[i].qi = 0; m_ent[i].vi = d; end
        if (hit(m_ent[i].qj, d)) begin m_ent[i].qj = 0; m_ent[i].vj = d; end
      end
    end
    if (valid_from_dispatcher && fr >= 0) begin
      ne.rob_alias = alias_from_dispatcher;
      ne.inst_type = inst_type_from_dispatcher;
      ne.qi = Qi_from_dispatcher;
      ne.vi = Vi_from_dispatcher;
      ne.qj = Qj_from_dispatcher;
      ne.vj = Vj_from_dispatcher;
      ne.imm = imm_from_dispatcher;
      ne.pc = pc_from_dispatcher;
      if (hit(ne.qi, d)) begin ne.qi = 0; ne.vi = d; end
      if (hit(ne.qj, d)) begin ne.qj = 0; ne.vj = d; end
      m_ent[fr] = ne;
      m_busy[fr] = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model, clock the DUT, compare after the edge.
  task automatic step();
    if (!rst && !rollback && rdy && valid_from_dispatcher && m_count() == RS_SIZE) begin
      n_err++;
      $display("FAIL protocol: dispatch into a completely busy station at %0t", $time);
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("full", 32'(full), 32'(m_count() >= RS_SIZE - 1));
    chk("valid_to_alu", 32'(valid_to_alu), 32'(m_valid));
    if (m_valid) begin
      chk("alias_to_alu", 32'(alias_to_alu), 32'(m_out.rob_alias));
      chk("inst_type_to_alu", 32'(inst_type_to_alu), 32'(m_out.inst_type));
      chk("Vi_to_alu", Vi_to_alu, m_out.vi);
      chk("Vj_to_alu", Vj_to_alu, m_out.vj);
      chk("imm_to_alu", imm_to_alu, m_out.imm);
      chk("pc_to_alu", pc_to_alu, m_out.pc);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1;
    rollback = 1'b0;
    valid_from_dispatcher = 1'b0;
    valid_from_alu = 1'b0;
    valid_from_lsb = 1'b0;
    alias_from_alu = '0;
    alias_from_lsb = '0;
    result_from_alu = '0;
    result_from_lsb = '0;
  endtask

  task automatic set_disp(rob_t a, rob_t qi, rob_t qj, data_t vi, data_t vj);
    valid_from_dispatcher = 1'b1;
    alias_from_dispatcher = a;
    inst_type_from_dispatcher = opt_t'($urandom_range(63, 0));
    Qi_from_dispatcher = qi;
    Qj_from_dispatcher = qj;
    Vi_from_dispatcher = vi;
    Vj_from_dispatcher = vj;
    imm_from_dispatcher = $urandom;
    pc_from_dispatcher = $urandom;
  endtask

  typedef struct {
    logic disp; rob_t a; rob_t qi; rob_t qj; data_t vi; data_t vj;
    logic bav; rob_t baa; data_t bar;
    logic blv; rob_t bla; data_t blr;
    logic ev; rob_t ea; data_t evi; data_t evj;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic disp, rob_t a, rob_t qi, rob_t qj, data_t vi, data_t vj,
                              logic bav, rob_t baa, data_t bar, logic blv, rob_t bla, data_t blr,
                              logic ev, rob_t ea, data_t evi, data_t evj);
    vec_t v;
    v.disp = disp; v.a = a; v.qi = qi; v.qj = qj; v.vi = vi; v.vj = vj;
    v.bav = bav; v.baa = baa; v.bar = bar; v.blv = blv; v.bla = bla; v.blr = blr;
    v.ev = ev; v.ea = ea; v.evi = evi; v.evj = evj;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < RS_SIZE; i++) begin m_busy[i] = 1'b0; m_ent[i] = '0; end
    m_valid = 1'b0;
    m_out = '0;
    idle_inputs();
    alias_from_dispatcher = '0; inst_type_from_dispatcher = '0;
    Qi_from_dispatcher = '0; Qj_from_dispatcher = '0;
    Vi_from_dispatcher = '0; Vj_from_dispatcher = '0;
    imm_from_dispatcher = '0; pc_from_dispatcher = '0;

    // Reset: all outputs must come up zero.
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(valid_to_alu), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_alias", 32'(alias_to_alu), 32'd0);
    chk("rst_type", 32'(inst_type_to_alu), 32'd0);
    chk("rst_vi", Vi_to_alu, 32'd0);
    chk("rst_vj", Vj_to_alu, 32'd0);
    chk("rst_imm", imm_to_alu, 32'd0);
    chk("rst_pc", pc_to_alu, 32'd0);
    rst = 1'b0;
    step();

    // Directed vectors: each row is driven for one cycle, expectations hold after its edge.
    tbl.push_back(mk(1, 3, 0, 0, 5, 7,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 3, 5, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 2, 0, 0, 1,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    1, 2, 'h10,  0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 4, 'h10, 1));
    tbl.push_back(mk(1, 5, 6, 7, 0, 0,    1, 6, 'hAA,  1, 7, 'hBB,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 5, 'hAA, 'hBB));
    tbl.push_back(mk(1, 7, 8, 8, 0, 0,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    1, 8, 'h11,  1, 8, 'h22,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 7, 'h11, 'h11));
    tbl.push_back(mk(1, 1, 0, 0, 1, 2,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 3, 4,    0, 0, 0,     0, 0, 0,     1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 2, 3, 4));
    tbl.push_back(mk(1, 6, 0, 0, 9, 'h33, 1, 0, 'hDEAD, 1, 0, 'hBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 6, 9, 'h33));
    tbl.push_back(mk(1, 8, 0, 12, 'h44, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     1, 12, 'h55, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     1, 8, 'h44, 'h55));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,     0, 0, 0, 0));

    foreach (tbl[k]) begin
      idle_inputs();
      if (tbl[k].disp) set_disp(tbl[k].a, tbl[k].qi, tbl[k].qj, tbl[k].vi, tbl[k].vj);
      valid_from_alu = tbl[k].bav; alias_from_alu = tbl[k].baa; result_from_alu = tbl[k].bar;
      valid_from_lsb = tbl[k].blv; alias_from_lsb = tbl[k].bla; result_from_lsb = tbl[k].blr;
      step();
      chk($sformatf("tbl%0d_valid", k), 32'(valid_to_alu), 32'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk($sformatf("tbl%0d_alias", k), 32'(alias_to_alu), 32'(tbl[k].ea));
        chk($sformatf("tbl%0d_vi", k), Vi_to_alu, tbl[k].evi);
        chk($sformatf("tbl%0d_vj", k), Vj_to_alu, tbl[k].evj);
      end
    end

    // Fill to 15 busy, then one in-flight dispatch into the last slot, then drain.
    for (int k = 0; k < 15; k++) begin
      idle_inputs();
      set_disp(rob_t'(k % 15 + 1), 4'd9, 4'd0, data_t'(k), data_t'(k + 100));
      step();
    end
    chk("full_at_15", 32'(full), 32'd1);
    idle_inputs();
    set_disp(4'd15, 4'd9, 4'd0, 32'h1616, 32'h0);
    step();
    chk("full_at_16", 32'(full), 32'd1);
    idle_inputs();
    valid_from_alu = 1'b1; alias_from_alu = 4'd9; result_from_alu = 32'h99;
    step();
    chk("wake_no_issue", 32'(valid_to_alu), 32'd0);
    idle_inputs();
    step();
    chk("drain_first_alias", 32'(alias_to_alu), 32'd1);
    chk("drain_first_vi", Vi_to_alu, 32'h99);
    chk("full_after_1_issue", 32'(full), 32'd1);
    step();
    chk("drain_second_alias", 32'(alias_to_alu), 32'd2);
    chk("full_after_2_issues", 32'(full), 32'd0);
    for (int k = 0; k < 16; k++) step();

    // Rollback together with a dispatch clears everything.
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      set_disp(rob_t'(k + 1), 4'd9, 4'd9, 32'h0, 32'h0);
      step();
    end
    idle_inputs();
    set_disp(4'd6, 4'd0, 4'd0, 32'h1, 32'h2);
    rollback = 1'b1;
    step();
    chk("rollback_valid", 32'(valid_to_alu), 32'd0);
    chk("rollback_full", 32'(full), 32'd0);
    idle_inputs();
    valid_from_alu = 1'b1; alias_from_alu = 4'd9; result_from_alu = 32'h5;
    step();
    idle_inputs();
    step();
    chk("rollback_no_issue", 32'(valid_to_alu), 32'd0);

    // rdy low: broadcasts ignored, outputs held.
    idle_inputs();
    set_disp(4'd2, 4'd3, 4'd0, 32'h0, 32'h21);
    step();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      rdy = 1'b0;
      valid_from_alu = 1'b1; alias_from_alu = 4'd3; result_from_alu = 32'h77;
      step();
      chk("rdy_low_no_issue", 32'(valid_to_alu), 32'd0);
    end
    idle_inputs();
    step();
    step();
    chk("rdy_low_bcast_ignored", 32'(valid_to_alu), 32'd0);
    valid_from_alu = 1'b1; alias_from_alu = 4'd3; result_from_alu = 32'h78;
    step();
    idle_inputs();
    step();
    chk("rdy_late_wake_valid", 32'(valid_to_alu), 32'd1);
    chk("rdy_late_wake_vi", Vi_to_alu, 32'h78);
    rdy = 1'b0;
    step();
    chk("rdy_low_hold_valid", 32'(valid_to_alu), 32'd1);
    chk("rdy_low_hold_alias", 32'(alias_to_alu), 32'd2);
    idle_inputs();
    step();
    chk("pulse_ends", 32'(valid_to_alu), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      idle_inputs();
      rdy = ($urandom_range(7, 0) != 0);
      rollback = ($urandom_range(63, 0) == 0);
      if (m_count() < RS_SIZE && $urandom_range(2, 0) != 0)
        set_disp(rob_t'($urandom_range(15, 1)),
                 ($urandom_range(2, 0) == 0) ? 4'd0 : rob_t'($urandom_range(7, 1)),
                 ($urandom_range(2, 0) == 0) ? 4'd0 : rob_t'($urandom_range(7, 1)),
                 $urandom, $urandom);
      valid_from_alu = ($urandom_range(1, 0) == 1);
      alias_from_alu = rob_t'($urandom_range(7, 0));
      result_from_alu = $urandom;
      valid_from_lsb = ($urandom_range(1, 0) == 1);
      alias_from_lsb = rob_t'($urandom_range(7, 0));
      result_from_lsb = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified ALU reservation station. It sits directly downstream of the dispatcher and upstream of the ALU.
- Buffers non-load/store instructions whose operands may still be pending ROB aliases.
- Snoops the ALU and LSB result broadcasts, and issues one ready instruction per cycle to the ALU.
- Drives the station-side contribution to the dispatcher `full` stall.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_WIDTH, 4, log2(RS_SIZE).
- ROB_WIDTH, 4, alias width; alias 0 means "no dependency".
- OPT_WIDTH, 6, instruction-type code width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- rollback  in  1  misprediction flush
- valid_from_dispatcher  in  1  dispatch strobe
- alias_from_dispatcher  in  ROB_WIDTH  destination ROB alias
- inst_type_from_dispatcher  in  OPT_WIDTH  operation code
- Vi_from_dispatcher, Vj_from_dispatcher  in  32  operand values
- Qi_from_dispatcher, Qj_from_dispatcher  in  ROB_WIDTH  pending aliases (0 = value valid)
- imm_from_dispatcher, pc_from_dispatcher  in  32  immediate, instruction pc
- valid_from_alu  in  1  ALU broadcast valid
- alias_from_alu  in  ROB_WIDTH  ALU broadcast alias
- result_from_alu  in  32  ALU broadcast value
- valid_from_lsb  in  1  LSB broadcast valid
- alias_from_lsb  in  ROB_WIDTH  LSB broadcast alias
- result_from_lsb  in  32  LSB broadcast value
- full  out  1  station nearly full (combinational)
- valid_to_alu  out  1  issue strobe
- alias_to_alu  out  ROB_WIDTH  issued alias
- inst_type_to_alu  out  OPT_WIDTH  issued operation code
- Vi_to_alu, Vj_to_alu, imm_to_alu, pc_to_alu  out  32  issued operands

Behaviour:
- Entry state: busy, alias, inst_type, Vi, Vj, Qi, Qj, imm, pc.
- Reset or rollback, at the clock edge: all busy flags cleared; valid_to_alu=0; every other output register set to 0. rst/rollback take priority over rdy.
- When rdy is low: no state change, outputs hold.
- full: combinational, `popcount(busy) >= RS_SIZE-1`.
  - One slot is kept spare because the dispatcher output is registered, so one dispatch may be in flight when full rises.
  - A dispatch arriving while all RS_SIZE entries are busy is a protocol violation; the bench flags it as an assertion and the write is dropped.
- Dispatch: on valid_from_dispatcher, write the lowest-index free entry (as seen at the start of the cycle).
  - Same-cycle wakeup: for each operand with nonzero Q matching a valid broadcast alias, store Q=0 and V=broadcast result.
  - The ALU broadcast is checked before the LSB broadcast.
- Wakeup: every cycle, each busy entry with Qi≠0 and Qi equal to a valid broadcast alias sets Qi<=0, Vi<=result. Same for Qj.
  - Both operands may be woken in one cycle, by the same or different broadcasts.
  - Broadcasts with alias 0 never match.
- Select: combinationally choose the lowest-index entry with busy && Qi==0 && Qj==0, using registered state only.
  - A just-written or just-woken entry is eligible in the following cycle.
- Issue: at the edge, the selected entry's fields are copied to the *_to_alu registers, valid_to_alu<=1, and the entry's busy<=0.
  - If nothing is selected, valid_to_alu<=0 (single-cycle pulse per instruction).
- Minimum latency: dispatch input sampled at edge T → entry valid after T → valid_to_alu high after edge T+1.
- Simultaneous dispatch and issue: both occur. A slot freed by issue is not reused in the same cycle.
- The ALU is always ready; there is no back-pressure.

Decomposition:
- utils.v holds DATA_RANGE, ROB_RANGE, OPT_RANGE, RS_SIZE/RS_WIDTH and the opcode constants.
- Sub-module rs_priority_enc(RS_SIZE): input vector → {found, lowest set index}.
  - Instance 1 on ~busy finds the free slot.
  - Instance 2 on the ready vector selects the issue entry.

Test Plan:
- Ready operands: dispatch alias=3, Qi=Qj=0, Vi=5, Vj=7, type ADD → valid_to_alu pulses one cycle, 2 edges after the dispatch sample, with alias 3, Vi=5, Vj=7; entry freed.
- Wakeup: dispatch alias=4 with Qi=2, Vj=1. Two cycles later, ALU broadcasts alias 2 with result 0x10 → issue next cycle with Vi=0x10.
- Same-cycle capture: dispatch Qi=6, Qj=7 while ALU broadcasts 6→0xAA and LSB broadcasts 7→0xBB → issue next cycle with Vi=0xAA, Vj=0xBB.
- Full: fill 15 entries with Qi=9 → full=1 with 15 busy. A 16th in-flight dispatch is accepted. Broadcast alias 9 → lowest index issues first, one per cycle, and full drops once busy ≤14.
- Rollback: 5 busy entries plus rollback asserted in the same cycle as a dispatch → next cycle all busy=0, valid_to_alu=0, full=0, nothing issues.
- rdy low: hold rdy=0 for 3 cycles during a pending broadcast → no wakeup or issue while low; broadcasts seen while rdy is low are ignored.
